// File: rtl/cpu_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_bus_pkg
//  Description : Shared constants for the CPU memory-bus responder: address
//                map bases/masks, FSM state and target-region encodings, the
//                error read pattern and the address decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_bus_pkg;

    // Address map (27-bit word addresses)
    localparam logic [26:0] c_RAM_BASE = 27'h0000000;
    localparam logic [26:0] c_ROM_BASE = 27'h4000000;
    localparam logic [26:0] c_IO_BASE  = 27'h4100000;
    localparam logic [26:0] c_IO_MASK  = 27'h0000007;

    // FSM state encoding
    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_RAM_WAIT = 2'd1;
    localparam logic [1:0] c_ST_ROM_WAIT = 2'd2;

    // Target region encoding
    localparam logic [1:0] c_RGN_RAM  = 2'd0;
    localparam logic [1:0] c_RGN_ROM  = 2'd1;
    localparam logic [1:0] c_RGN_IO   = 2'd2;
    localparam logic [1:0] c_RGN_NONE = 2'd3;

    // Read data returned when a RAM access times out
    localparam logic [31:0] c_ERR_DATA = 32'hDEADBEEF;

    // RAM owns the whole lower half; the ROM window size follows rom_aw.
    function automatic logic [1:0] decode_region(input logic [26:0] a,
                                                 input int          rom_aw);
        logic [26:0] w_rom_mask;
        w_rom_mask = (27'd1 << rom_aw) - 27'd1;
        if (a[26] == 1'b0)                         return c_RGN_RAM;
        if ((a & ~w_rom_mask) == c_ROM_BASE)       return c_RGN_ROM;
        if ((a & ~c_IO_MASK) == c_IO_BASE)         return c_RGN_IO;
        return c_RGN_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : io_regfile
//  Description : Eight 32-bit on-chip I/O registers. Registers 0-6 are R/W
//                scratch; register 7 is a read-only wrapping counter of
//                completed bus transactions.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                i_we          - write strobe (ignored for register 7)
//                i_addr        - register index (shared by read and write)
//                i_wdata       - write data
//                i_inc         - increment register 7 this cycle
//                o_rdata       - combinational read of register i_addr
//  Revision    : 1.0 - initial release
// ============================================================================
module io_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_we,
    input  logic [2:0]  i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_inc,
    output logic [31:0] o_rdata
);

    logic [31:0] r_regs [0:7];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else begin
            if (i_we && (i_addr != 3'd7)) begin
                r_regs[i_addr] <= i_wdata;
            end
            if (i_inc) begin
                r_regs[7] <= r_regs[7] + 32'd1;
            end
        end
    end

    // Read is combinational so a read of register 7 on its completion edge
    // returns the value before that edge's increment.
    assign o_rdata = r_regs[i_addr];

endmodule
`default_nettype wire

// File: rtl/mem_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_responder
//  Description : Target side of the CPU memory bus. Accepts one transaction
//                at a time, decodes it to RAM backend, synchronous ROM, I/O
//                registers or unmapped space, and returns busy/q.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                address/data/we     - CPU request, latched on accepted start
//                start               - 1-cycle request pulse
//                q, busy             - read data / transaction in progress
//                mem_addr/d/we/req   - RAM backend request (level)
//                mem_ack, mem_q      - RAM backend completion and read data
//                rom_addr, rom_q     - synchronous ROM interface
//                bus_error           - 1-cycle pulse on RAM timeout
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_responder
    import cpu_bus_pkg::*;
#(
    parameter int ROM_AW  = 10,
    parameter int ROM_LAT = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [26:0]       address,
    input  logic [31:0]       data,
    input  logic              we,
    input  logic              start,
    output logic [31:0]       q,
    output logic              busy,
    output logic [25:0]       mem_addr,
    output logic [31:0]       mem_d,
    output logic              mem_we,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [31:0]       mem_q,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_q,
    output logic              bus_error
);

    localparam int c_ROM_CW = $clog2(ROM_LAT + 1);
    localparam int c_TO_CW  = $clog2(TIMEOUT + 1);

    logic [1:0]          r_state;
    logic                r_busy;
    logic [1:0]          r_region;
    logic                r_we;
    logic [2:0]          r_io_idx;
    logic [31:0]         r_data;
    logic [31:0]         r_q;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [25:0]         r_mem_addr;
    logic [31:0]         r_mem_d;
    logic [ROM_AW-1:0]   r_rom_addr;
    logic                r_bus_error;
    logic [c_ROM_CW-1:0] r_rom_cnt;
    logic [c_TO_CW-1:0]  r_to_cnt;

    logic [1:0]          w_region;
    logic                w_single_done;
    logic                w_rom_done;
    logic                w_ram_done;
    logic                w_done;
    logic                w_io_we;
    logic [31:0]         w_io_rdata;

    assign w_region = decode_region(address, ROM_AW);

    // IDLE with busy set means a one-cycle target (IO, unmapped, ROM write)
    // is completing this cycle; new starts are only accepted with busy low.
    assign w_single_done = (r_state == c_ST_IDLE) && r_busy;
    assign w_rom_done    = (r_state == c_ST_ROM_WAIT) && (r_rom_cnt == '0);
    assign w_ram_done    = (r_state == c_ST_RAM_WAIT) &&
                           (mem_ack || (r_to_cnt == c_TO_CW'(TIMEOUT - 1)));
    assign w_done        = w_single_done || w_rom_done || w_ram_done;
    assign w_io_we       = w_single_done && r_we && (r_region == c_RGN_IO);

    io_regfile u_io_regfile (
        .clk     (clk),
        .rst     (reset),
        .i_we    (w_io_we),
        .i_addr  (r_io_idx),
        .i_wdata (r_data),
        .i_inc   (w_done),
        .o_rdata (w_io_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_busy      <= 1'b0;
            r_region    <= c_RGN_RAM;
            r_we        <= 1'b0;
            r_io_idx    <= 3'd0;
            r_data      <= 32'd0;
            r_q         <= 32'd0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 26'd0;
            r_mem_d     <= 32'd0;
            r_rom_addr  <= '0;
            r_bus_error <= 1'b0;
            r_rom_cnt   <= '0;
            r_to_cnt    <= '0;
        end else begin
            r_bus_error <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (r_busy) begin
                        // Writes to unmapped space or ROM are simply dropped.
                        if (!r_we && (r_region == c_RGN_IO)) begin
                            r_q <= w_io_rdata;
                        end else if (!r_we && (r_region == c_RGN_NONE)) begin
                            r_q <= 32'd0;
                        end
                        r_busy <= 1'b0;
                    end else if (start) begin
                        r_busy   <= 1'b1;
                        r_region <= w_region;
                        r_we     <= we;
                        r_io_idx <= address[2:0];
                        r_data   <= data;
                        if (w_region == c_RGN_RAM) begin
                            r_state    <= c_ST_RAM_WAIT;
                            r_mem_req  <= 1'b1;
                            r_mem_we   <= we;
                            r_mem_addr <= address[25:0];
                            r_mem_d    <= data;
                            r_to_cnt   <= '0;
                        end else if ((w_region == c_RGN_ROM) && !we) begin
                            // Loading LAT-1 and finishing at zero keeps busy
                            // high for exactly ROM_LAT cycles.
                            r_state    <= c_ST_ROM_WAIT;
                            r_rom_addr <= address[ROM_AW-1:0];
                            r_rom_cnt  <= c_ROM_CW'(ROM_LAT - 1);
                        end
                    end
                end
                c_ST_RAM_WAIT: begin
                    if (mem_ack) begin
                        // Ack takes priority over a coincident timeout.
                        r_mem_req <= 1'b0;
                        if (!r_we) begin
                            r_q <= mem_q;
                        end
                        r_busy  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end else if (r_to_cnt == c_TO_CW'(TIMEOUT - 1)) begin
                        r_mem_req   <= 1'b0;
                        r_bus_error <= 1'b1;
                        if (!r_we) begin
                            r_q <= c_ERR_DATA;
                        end
                        r_busy  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                c_ST_ROM_WAIT: begin
                    if (r_rom_cnt == '0) begin
                        r_q     <= rom_q;
                        r_busy  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_rom_cnt <= r_rom_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign q         = r_q;
    assign busy      = r_busy;
    assign mem_addr  = r_mem_addr;
    assign mem_d     = r_mem_d;
    assign mem_we    = r_mem_we;
    assign mem_req   = r_mem_req;
    assign rom_addr  = r_rom_addr;
    assign bus_error = r_bus_error;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bus_responder
//  Description : Directed self-checking bench for mem_bus_responder
//                (ROM_AW=10, ROM_LAT=2, TIMEOUT=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_responder;

    logic        clk;
    logic        reset;
    logic [26:0] address;
    logic [31:0] data;
    logic        we;
    logic        start;
    logic [31:0] q;
    logic        busy;
    logic [25:0] mem_addr;
    logic [31:0] mem_d;
    logic        mem_we;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_q;
    logic [9:0]  rom_addr;
    logic [31:0] rom_q;
    logic        bus_error;

    int errors = 0;
    int checks = 0;
    int n;

    mem_bus_responder #(
        .ROM_AW  (10),
        .ROM_LAT (2),
        .TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .data      (data),
        .we        (we),
        .start     (start),
        .q         (q),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_d     (mem_d),
        .mem_we    (mem_we),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .mem_q     (mem_q),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .bus_error (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM content: a fixed pattern of the address, stable while rom_addr holds
    assign rom_q = {16'hB00B, 6'd0, rom_addr};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One-cycle target: busy high for exactly one cycle after the accept edge
    task automatic single(input string tag, input logic [26:0] a, input logic [31:0] d,
                          input logic w);
        address = a; data = d; we = w; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_hi"}, {31'd0, busy}, 32'd1);
        tick();
        chk({tag, "_busy_lo"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; address = '0; data = '0; we = 1'b0; start = 1'b0;
        mem_ack = 1'b0; mem_q = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_q", q, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_bus_error", {31'd0, bus_error}, 32'd0);
        chk("rst_rom_addr", {22'd0, rom_addr}, 32'd0);
        chk("rst_mem_addr", {6'd0, mem_addr}, 32'd0);

        // I/O write then read-back of register 3 (completion 1, 2)
        single("io_wr3", 27'h4100003, 32'h12345678, 1'b1);
        chk("io_wr3_q", q, 32'd0);
        single("io_rd3", 27'h4100003, 32'h0, 1'b0);
        chk("io_rd3_q", q, 32'h12345678);
        // Counter read returns the pre-increment value (completion 3)
        single("io_rd7a", 27'h4100007, 32'h0, 1'b0);
        chk("io_rd7a_q", q, 32'd2);

        // RAM read, ack during the 5th request cycle (completion 4)
        address = 27'h0000123; we = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ram_rd_busy", {31'd0, busy}, 32'd1);
        chk("ram_rd_addr", {6'd0, mem_addr}, 32'h123);
        chk("ram_rd_we", {31'd0, mem_we}, 32'd0);
        n = 0;
        for (int i = 1; i <= 5; i++) begin
            if (mem_req) n++;
            if (i == 5) begin
                mem_ack = 1'b1; mem_q = 32'hCAFEF00D;
            end
            tick();
            mem_ack = 1'b0;
        end
        chk("ram_rd_req_cycles", n, 32'd5);
        chk("ram_rd_req_lo", {31'd0, mem_req}, 32'd0);
        chk("ram_rd_busy_lo", {31'd0, busy}, 32'd0);
        chk("ram_rd_q", q, 32'hCAFEF00D);

        // RAM read with no ack: abort after 8 request cycles (completion 5)
        address = 27'h0000200; we = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && busy; i++) begin
            if (mem_req) n++;
            chk("to_no_err_early", {31'd0, bus_error}, 32'd0);
            tick();
        end
        chk("to_busy_lo", {31'd0, busy}, 32'd0);
        chk("to_req_cycles", n, 32'd8);
        chk("to_bus_error", {31'd0, bus_error}, 32'd1);
        chk("to_q", q, 32'hDEADBEEF);
        chk("to_req_lo", {31'd0, mem_req}, 32'd0);
        tick();
        chk("to_bus_error_pulse", {31'd0, bus_error}, 32'd0);

        // RAM write at top of RAM, immediate ack; q untouched (completion 6)
        address = 27'h3FFFFFF; data = 32'h0000A5A5; we = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ram_wr_we", {31'd0, mem_we}, 32'd1);
        chk("ram_wr_d", mem_d, 32'h0000A5A5);
        chk("ram_wr_addr", {6'd0, mem_addr}, 32'h3FFFFFF);
        mem_ack = 1'b1; mem_q = 32'h77777777;
        tick();
        mem_ack = 1'b0;
        chk("ram_wr_busy_lo", {31'd0, busy}, 32'd0);
        chk("ram_wr_q_kept", q, 32'hDEADBEEF);

        // ROM read, busy for ROM_LAT=2 cycles (completion 7)
        address = 27'h4000010; we = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("rom_addr", {22'd0, rom_addr}, 32'h010);
        chk("rom_busy1", {31'd0, busy}, 32'd1);
        tick();
        chk("rom_busy2", {31'd0, busy}, 32'd1);
        tick();
        chk("rom_busy_lo", {31'd0, busy}, 32'd0);
        chk("rom_q", q, 32'hB00B0010);

        // ROM read with a start pulsed while busy (completion 8)
        address = 27'h4000020; we = 1'b0; start = 1'b1;
        tick();
        address = 27'h4100000; data = 32'h0000FFFF; we = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("ign_busy_lo", {31'd0, busy}, 32'd0);
        chk("ign_rom_q", q, 32'hB00B0020);
        tick();
        chk("ign_not_queued", {31'd0, busy}, 32'd0);
        // Stray ack in IDLE
        mem_ack = 1'b1; mem_q = 32'h11111111;
        tick();
        mem_ack = 1'b0;
        chk("stray_ack_q", q, 32'hB00B0020);
        chk("stray_ack_busy", {31'd0, busy}, 32'd0);
        chk("stray_ack_req", {31'd0, mem_req}, 32'd0);

        single("io_rd7b", 27'h4100007, 32'h0, 1'b0);        // completion 9
        chk("io_rd7b_q", q, 32'd8);
        single("rom_wr", 27'h4000001, 32'h99999999, 1'b1);  // completion 10
        chk("rom_wr_q_kept", q, 32'd8);
        single("unmap_rd", 27'h4200000, 32'h0, 1'b0);       // completion 11
        chk("unmap_rd_q", q, 32'd0);
        single("io_wr7", 27'h4100007, 32'h00000055, 1'b1);  // completion 12
        single("io_rd0", 27'h4100000, 32'h0, 1'b0);         // completion 13
        chk("io_rd0_q", q, 32'd0);
        single("io_rd7c", 27'h4100007, 32'h0, 1'b0);        // completion 14
        chk("io_rd7c_q", q, 32'd13);

        // Reset in the middle of RAM_WAIT
        address = 27'h0000040; we = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("mid_req_hi", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
        chk("mid_rst_q", q, 32'd0);
        mem_ack = 1'b1; mem_q = 32'h22222222;
        tick();
        mem_ack = 1'b0;
        chk("mid_late_ack_q", q, 32'd0);
        chk("mid_late_ack_busy", {31'd0, busy}, 32'd0);
        single("io_rd7d", 27'h4100007, 32'h0, 1'b0);
        chk("io_rd7d_q", q, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
